sb_config_loader: RTL and testbench

Configuration write sequencer sitting directly upstream of the tile switch box. It accepts a stream of 32-bit configuration words over a valid/ready interface as alternating address/data pairs, decodes tile and feature IDs, and issues single-cycle `config_addr`/`config_data`/`config_en` writes that the switch box's configuration register consumes. Non-matching pairs are dropped and counted.

---
 rtl/sb_config_loader.sv | 127 ++++++++++++
 tb/tb_sb_config_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_loader.sv
// Purpose : turns a stream of address/data word pairs into single-cycle switch-box config writes.
// Latency : address accepted in cycle N, data in N+1, config_en high in N+2.
// Backpressure: in_ready depends on state only; it is low for the single S_WRITE cycle.
//
// Ports:
//   clk, reset (sync, active-low)        - clock and reset
//   flush                                - drop any half-received pair, resync to address phase
//   in_valid / in_ready / in_data[31:0]  - word stream, alternating address and data
//   config_addr[31:0], config_data[31:0] - last captured address / data words
//   config_en                            - one-cycle write strobe to the switch box
//   busy                                 - loader is mid-pair or writing
//   write_count[7:0], drop_count[7:0]    - saturating issued-write / dropped-pair counters
module sb_config_loader #(
  parameter logic [15:0] TILE_ID    = 16'h0001,
  parameter logic [15:0] BCAST_ID   = 16'hFFFF,
  parameter logic [7:0]  FEATURE_ID = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_en,
  output logic        busy,
  output logic [7:0]  write_count,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic        en_q, en_d;

  logic accept;
  logic addr_match;

  // in_ready is a pure state decode, so there is no path from in_valid.
  assign in_ready = (state_q != S_WRITE);
  assign accept   = in_valid && in_ready;

  // Broadcast relaxes only the tile field; the feature field must always match.
  assign addr_match = ((addr_q[31:16] == TILE_ID) || (addr_q[31:16] == BCAST_ID)) &&
                      (addr_q[15:8] == FEATURE_ID);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      S_ADDR: begin
        // A handshake during flush is consumed and discarded.
        if (flush) begin
          state_d = S_ADDR;
        end else if (accept) begin
          addr_d  = in_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (flush) begin
          state_d = S_ADDR;
        end else if (accept) begin
          data_d = in_data;
          if (addr_match) begin
            state_d = S_WRITE;
          end else begin
            dcnt_d  = (dcnt_q == 8'hFF) ? dcnt_q : dcnt_q + 8'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_WRITE: begin
        // The strobe is already on the wire this cycle, so the write is
        // counted even if flush arrives alongside it.
        wcnt_d  = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        state_d = S_ADDR;
      end
      default: begin
        state_d = S_ADDR;
      end
    endcase

    // Strobe comes straight from a flop so the switch box sees a clean pulse
    // exactly while the FSM sits in S_WRITE.
    en_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_ADDR;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wcnt_q  <= 8'd0;
      dcnt_q  <= 8'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
    end
  end

  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_en   = en_q;
  assign busy        = (state_q != S_ADDR);
  assign write_count = wcnt_q;
  assign drop_count  = dcnt_q;

endmodule

// File: tb/tb_sb_config_loader.sv
module tb_sb_config_loader;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic        busy;
  logic [7:0]  write_count;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int en_pulses = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  sb_config_loader dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_en   (config_en),
    .busy        (busy),
    .write_count (write_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode of an address word.
  function automatic bit model_match(input logic [31:0] a);
    return ((a[31:16] == 16'h0001) || (a[31:16] == 16'hFFFF)) && (a[15:8] == 8'h00);
  endfunction

  // Scoreboard consumer: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (config_en === 1'b1) begin
      en_pulses++;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("sb_addr", config_addr, exp_addr_q.pop_front());
        check("sb_data", config_data, exp_data_q.pop_front());
      end
    end
  end

  // Present one word and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] w);
    logic acc;
    in_valid = 1'b1;
    in_data  = w;
    acc      = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] d);
    if (model_match(a)) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
    end
    send(a);
    send(d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    int p0;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    idle(2);
    reset = 1'b1;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_addr", config_addr, 0);
    check("rst_data", config_data, 0);
    check("rst_en", config_en, 0);
    check("rst_busy", busy, 0);
    check("rst_wcnt", write_count, 0);
    check("rst_dcnt", drop_count, 0);

    // Basic write with exact latency
    exp_addr_q.push_back(32'h0001_0000);
    exp_data_q.push_back(32'h0000_0C00);
    in_valid = 1'b1; in_data = 32'h0001_0000;
    idle(1);                                       // address accepted (cycle N)
    check("w1_busy_after_addr", busy, 1);
    check("w1_en_n1", config_en, 0);
    in_data = 32'h0000_0C00;
    idle(1);                                       // data accepted (N+1), now in N+2
    in_valid = 1'b0;
    check("w1_en_n2", config_en, 1);
    check("w1_ready_write", in_ready, 0);
    check("w1_data", config_data, 32'h0000_0C00);
    idle(1);
    check("w1_en_off", config_en, 0);
    check("w1_wcnt", write_count, 1);
    check("w1_pulses", en_pulses, 1);

    // Mismatches: wrong tile, wrong feature
    do_reset();
    p0 = en_pulses;
    send_pair(32'h0002_0000, 32'h0000_1111);
    send_pair(32'h0001_0100, 32'h0000_2222);
    idle(2);
    check("mm_dcnt", drop_count, 2);
    check("mm_wcnt", write_count, 0);
    check("mm_no_en", en_pulses - p0, 0);

    // Broadcast with bubbles inside the pair
    do_reset();
    p0 = en_pulses;
    send(32'hFFFF_0000);
    exp_addr_q.push_back(32'hFFFF_0000);
    exp_data_q.push_back(32'h0000_0400);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("bc_gap_busy", busy, 1);
      check("bc_gap_ready", in_ready, 1);
    end
    send(32'h0000_0400);
    check("bc_write_ready", in_ready, 0);
    check("bc_write_busy", busy, 1);
    check("bc_write_data", config_data, 32'h0000_0400);
    idle(1);
    check("bc_after_ready", in_ready, 1);
    check("bc_after_busy", busy, 0);
    check("bc_pulses", en_pulses - p0, 1);

    // Flush mid-pair, with a word offered during the flush cycle
    do_reset();
    p0 = en_pulses;
    send(32'h0001_0000);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_busy", busy, 0);
    check("fl_addr_kept", config_addr, 32'h0001_0000);
    send_pair(32'h0001_0000, 32'h0000_0800);
    idle(2);
    check("fl_pulses", en_pulses - p0, 1);
    check("fl_data", config_data, 32'h0000_0800);
    check("fl_dcnt", drop_count, 0);
    check("fl_wcnt", write_count, 1);

    // Reset mid-pair while a word is offered
    send(32'h0001_0000);
    reset = 1'b0; in_valid = 1'b1; in_data = 32'h0000_5555;
    idle(1);
    reset = 1'b1; in_valid = 1'b0;
    check("mr_addr", config_addr, 0);
    check("mr_data", config_data, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 1);
    check("mr_en", config_en, 0);
    check("mr_wcnt", write_count, 0);
    check("mr_dcnt", drop_count, 0);
    send_pair(32'h0001_0000, 32'h0000_0C00);
    idle(1);
    check("mr_next_is_addr_wcnt", write_count, 1);

    // Saturation of write_count
    for (int k = 0; k < 253; k++) send_pair(32'h0001_00A5, k);
    idle(1);
    check("sat_fe", write_count, 8'hFE);
    send_pair(32'h0001_0000, 32'h0000_0001);
    idle(1);
    check("sat_ff", write_count, 8'hFF);
    for (int k = 0; k < 6; k++) send_pair(32'hFFFF_0000, 32'h0000_0F00 + k);
    idle(1);
    check("sat_hold", write_count, 8'hFF);
    check("sat_dcnt", drop_count, 0);

    idle(3);
    check("sb_empty", exp_addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
